// File: rtl/calc_op_sched_if.sv
// calc_op_sched_if: request/overflow inputs and datapath strobes of the calculator op scheduler
interface calc_op_sched_if;
  logic       ad, su, mu, v;
  logic       ld_x, ld_y, ld_y2c, mul_clr, mul_step, ld_res, done, busy;
  logic [1:0] alu_op, err;
  modport master (output ad, su, mu, v,
                  input ld_x, ld_y, ld_y2c, alu_op, mul_clr, mul_step, ld_res, done, busy, err);
  modport slave  (input ad, su, mu, v,
                  output ld_x, ld_y, ld_y2c, alu_op, mul_clr, mul_step, ld_res, done, busy, err);
endinterface

// File: rtl/calc_op_sched.sv
// calc_op_sched: sequences x/y load, settle, shift-add multiply and result commit; all outputs registered
module calc_op_sched #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  calc_op_sched_if.slave bus
);
  localparam int MX = (WIDTH > SETTLE) ? WIDTH : SETTLE;
  localparam int CW = (MX < 2) ? 1 : $clog2(MX);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_MSTEP, S_COMMIT, S_DONE, S_HOLD} state_t;
  state_t        state_q, state_d, run_st;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d, err_q, err_d, alu_op_q, alu_op_d, nreq;
  logic          ovf_q, ovf_d, commit_ovf, is_mul;
  logic          ld_x_q, ld_x_d, ld_y_q, ld_y_d, ld_y2c_q, ld_y2c_d, mul_clr_q, mul_clr_d;
  logic          mul_step_q, mul_step_d, ld_res_q, ld_res_d, done_q, done_d, busy_q, busy_d;
  assign nreq   = 2'(bus.ad) + 2'(bus.su) + 2'(bus.mu);
  assign is_mul = op_q == OP_MUL;
  assign run_st = is_mul ? S_MSTEP : S_COMMIT;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      ovf_q      <= 1'b0;
      err_q      <= 2'b00;
      alu_op_q   <= 2'b00;
      ld_x_q     <= 1'b0;
      ld_y_q     <= 1'b0;
      ld_y2c_q   <= 1'b0;
      mul_clr_q  <= 1'b0;
      mul_step_q <= 1'b0;
      ld_res_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      alu_op_q   <= alu_op_d;
      ld_x_q     <= ld_x_d;
      ld_y_q     <= ld_y_d;
      ld_y2c_q   <= ld_y2c_d;
      mul_clr_q  <= mul_clr_d;
      mul_step_q <= mul_step_d;
      ld_res_q   <= ld_res_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (nreq == 2'd1) begin
          state_d = S_LOAD;
          op_d    = bus.mu ? OP_MUL : bus.su ? OP_SUB : OP_ADD;
          err_d   = 2'b00;
          ovf_d   = 1'b0;
        end else if (nreq > 2'd1) begin
          state_d  = S_HOLD;
          err_d[1] = 1'b1;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? S_SETTLE : run_st;
      end
      S_SETTLE: begin
        cnt_d   = (cnt_q == CW'(SETTLE - 1)) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q == CW'(SETTLE - 1)) ? run_st : S_SETTLE;
      end
      S_MSTEP: begin
        ovf_d   = ovf_q | bus.v;
        cnt_d   = (cnt_q == CW'(WIDTH - 1)) ? cnt_q : cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? S_COMMIT : S_MSTEP;
      end
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_HOLD;
      S_HOLD:   state_d = (nreq == 2'd0) ? S_IDLE : S_HOLD;
      default:  state_d = S_HOLD;
    endcase
    // ld_res is registered, so the overflow verdict is taken on the edge entering COMMIT
    commit_ovf = is_mul ? ovf_d : bus.v;
    if (state_d == S_COMMIT && commit_ovf) err_d[0] = 1'b1;
  end
  always_comb begin
    ld_x_d     = state_d == S_LOAD;
    ld_y_d     = state_d == S_LOAD && op_d != OP_SUB;
    ld_y2c_d   = state_d == S_LOAD && op_d == OP_SUB;
    mul_clr_d  = state_d == S_LOAD && op_d == OP_MUL;
    mul_step_d = state_d == S_MSTEP;
    ld_res_d   = state_d == S_COMMIT && !commit_ovf;
    done_d     = state_d == S_DONE;
    busy_d     = state_d != S_IDLE;
    alu_op_d   = (state_d == S_IDLE || state_d == S_HOLD) ? 2'b00 : op_d;
  end
  assign bus.ld_x     = ld_x_q;
  assign bus.ld_y     = ld_y_q;
  assign bus.ld_y2c   = ld_y2c_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.mul_clr  = mul_clr_q;
  assign bus.mul_step = mul_step_q;
  assign bus.ld_res   = ld_res_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_calc_op_sched.sv
// tb_calc_op_sched: drives a SETTLE=1 and a SETTLE=0 scheduler with shared stimulus and checks
// each cycle against an operation-timeline model
module tb_calc_op_sched;
  localparam int W = 8;
  logic clk, rst, ad, su, mu, v;
  logic [11:0] o1, o0;
  int tests, fails, r_len;
  bit cur_a, cur_s, cur_m;
  bit vh[64];
  logic [1:0] ep1, ep0;
  calc_op_sched_if b1();
  calc_op_sched_if b0();
  assign b1.ad = ad;
  assign b1.su = su;
  assign b1.mu = mu;
  assign b1.v  = v;
  assign b0.ad = ad;
  assign b0.su = su;
  assign b0.mu = mu;
  assign b0.v  = v;
  calc_op_sched #(.WIDTH(W), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  calc_op_sched #(.WIDTH(W), .SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  assign o1 = {b1.ld_x, b1.ld_y, b1.ld_y2c, b1.alu_op, b1.mul_clr, b1.mul_step,
               b1.ld_res, b1.done, b1.busy, b1.err};
  assign o0 = {b0.ld_x, b0.ld_y, b0.ld_y2c, b0.alu_op, b0.mul_clr, b0.mul_step,
               b0.ld_res, b0.done, b0.busy, b0.err};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct {
    bit a, s, m;
    int vm;
    bit garb;
    logic [1:0] e1, e0;
    int d1, d0;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [11:0] pk(input bit lx, ly, l2, input logic [1:0] op,
                                     input bit mc, ms, lr, dn, bs, input logic [1:0] e);
    return {lx, ly, l2, op, mc, ms, lr, dn, bs, e};
  endfunction
  // Expected outputs k cycles after the acceptance edge for a scheduler with S settle cycles
  function automatic logic [11:0] expv(input int sc, input int k, input logic [1:0] ep);
    int n, kc, kd, hl;
    bit mul, ovf;
    logic [1:0] op, e;
    n   = int'(cur_a) + int'(cur_s) + int'(cur_m);
    op  = cur_m ? 2'b10 : cur_s ? 2'b01 : 2'b00;
    mul = cur_m && n == 1;
    if (n == 0) return pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, ep);
    if (n > 1) return pk(0, 0, 0, 2'b00, 0, 0, 0, 0, k <= r_len, ep | 2'b10);
    kc  = 1 + sc + (mul ? W : 0);
    kd  = kc + 1;
    ovf = 1'b0;
    if (k >= kc) begin
      if (mul) for (int j = sc + 1; j <= sc + W; j++) ovf |= vh[j];
      else ovf = vh[kc-1];
    end
    e  = {1'b0, ovf};
    hl = (r_len > kd + 1) ? r_len : kd + 1;
    if (k == 0) return pk(1, op != 2'b01, op == 2'b01, op, mul, 0, 0, 0, 1, 2'b00);
    if (k <= sc) return pk(0, 0, 0, op, 0, 0, 0, 0, 1, 2'b00);
    if (k < kc) return pk(0, 0, 0, op, 0, 1, 0, 0, 1, 2'b00);
    if (k == kc) return pk(0, 0, 0, op, 0, 0, !ovf, 0, 1, e);
    if (k == kd) return pk(0, 0, 0, op, 0, 0, 0, 1, 1, e);
    return pk(0, 0, 0, 2'b00, 0, 0, 0, 0, k <= hl, e);
  endfunction
  // Starts right after a negedge with both schedulers idle; leaves them idle after a negedge
  task automatic do_op(input bit a, s, m, input int vm, input bit garb,
                       output int d1, output int d0, output logic [1:0] e1, output logic [1:0] e0);
    int n, kd1, kd0, len;
    logic [11:0] t1, t0;
    bit mul;
    cur_a = a;
    cur_s = s;
    cur_m = m;
    foreach (vh[i]) vh[i] = 1'b0;
    n     = int'(a) + int'(s) + int'(m);
    mul   = m && n == 1;
    kd1   = 3 + (mul ? W : 0);
    kd0   = 2 + (mul ? W : 0);
    r_len = (n == 1) ? kd1 + 1 + int'($urandom_range(0, 3)) : 1 + int'($urandom_range(0, 3));
    len   = r_len + 3;
    d1 = -1;
    d0 = -1;
    ad = a;
    su = s;
    mu = m;
    v  = 1'b0;
    for (int k = 0; k <= len; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("trace_s1_k%0d", k), 32'(o1), 32'(expv(1, k, ep1)));
      chk($sformatf("trace_s0_k%0d", k), 32'(o0), 32'(expv(0, k, ep0)));
      if (o1[3] && d1 < 0) d1 = k;
      if (o0[3] && d0 < 0) d0 = k;
      @(negedge clk);
      v = (vm == 1) ? 1'b1 : (vm == 3) ? (k == 4) : (vm == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      vh[k] = v;
      if (n == 1 && garb && k < kd0) {ad, su, mu} = 3'($urandom_range(0, 7));
      else if (k < r_len) {ad, su, mu} = {a, s, m};
      else {ad, su, mu} = 3'b000;
    end
    t1 = expv(1, len, ep1);
    t0 = expv(0, len, ep0);
    ep1 = t1[1:0];
    ep0 = t0[1:0];
    e1 = o1[1:0];
    e0 = o0[1:0];
  endtask
  initial begin
    int d1, d0;
    logic [1:0] e1, e0;
    bit ra, rs, rm;
    tv[0]  = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 3, 2};
    tv[1]  = '{1, 1, 0, 0, 0, 2'b10, 2'b10, -1, -1};
    tv[2]  = '{1, 1, 1, 0, 0, 2'b10, 2'b10, -1, -1};
    tv[3]  = '{1, 0, 0, 0, 1, 2'b00, 2'b00, 3, 2};
    tv[4]  = '{0, 1, 0, 1, 0, 2'b01, 2'b01, 3, 2};
    tv[5]  = '{0, 1, 1, 0, 0, 2'b11, 2'b11, -1, -1};
    tv[6]  = '{0, 0, 1, 0, 1, 2'b00, 2'b00, 11, 10};
    tv[7]  = '{0, 0, 1, 3, 0, 2'b01, 2'b01, 11, 10};
    tv[8]  = '{0, 1, 0, 0, 1, 2'b00, 2'b00, 3, 2};
    tv[9]  = '{0, 0, 0, 0, 0, 2'b00, 2'b00, -1, -1};
    tv[10] = '{1, 0, 0, 1, 0, 2'b01, 2'b01, 3, 2};
    tv[11] = '{1, 0, 1, 0, 0, 2'b11, 2'b11, -1, -1};
    tests = 0;
    fails = 0;
    ep1 = 2'b00;
    ep0 = 2'b00;
    rst = 1'b1;
    ad = 1'b0;
    su = 1'b0;
    mu = 1'b0;
    v  = 1'b0;
    #1 rst = 1'b0;
    #3;
    chk("reset_state_s1", 32'(o1), 32'h0);
    chk("reset_state_s0", 32'(o0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      do_op(tv[i].a, tv[i].s, tv[i].m, tv[i].vm, tv[i].garb, d1, d0, e1, e0);
      chk($sformatf("vec%0d_done_cycle_s1", i), 32'(d1), 32'(tv[i].d1));
      chk($sformatf("vec%0d_done_cycle_s0", i), 32'(d0), 32'(tv[i].d0));
      chk($sformatf("vec%0d_err_s1", i), 32'(e1), 32'(tv[i].e1));
      chk($sformatf("vec%0d_err_s0", i), 32'(e0), 32'(tv[i].e0));
    end
    mu = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("reset_mid_mul_s1", 32'(o1), 32'h0);
    chk("reset_mid_mul_s0", 32'(o0), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("held_after_reset_s1", 32'(o1), 32'h004);
      chk("held_after_reset_s0", 32'(o0), 32'h004);
    end
    @(negedge clk);
    mu = 1'b0;
    @(posedge clk);
    #1;
    chk("release_after_reset_s1", 32'(o1), 32'h0);
    chk("release_after_reset_s0", 32'(o0), 32'h0);
    ep1 = 2'b00;
    ep0 = 2'b00;
    @(negedge clk);
    do_op(0, 0, 1, 0, 0, d1, d0, e1, e0);
    chk("rearm_mul_done_s1", 32'(d1), 32'd11);
    chk("rearm_mul_done_s0", 32'(d0), 32'd10);
    for (int i = 0; i < 40; i++) begin
      {ra, rs, rm} = 3'($urandom_range(0, 7));
      do_op(ra, rs, rm, rm ? 2 : int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d1, d0, e1, e0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc_op_sched.md
Name: calc_op_sched

Overview:
- Top-level operation scheduler for the calculator datapath.
- Accepts level-sensitive operation requests (add, subtract, multiply) from the mode switches and validates that exactly one is active.
- Sequences the shared x/y registers, the ALU and the result register.
- Adds settle cycles for the ALU critical path, runs a WIDTH-step shift-add multiply, reports overflow or illegal requests, and re-arms only after all requests are released.

Parameters:
- WIDTH, 8: operand width; number of multiply steps.
- SETTLE, 1: idle cycles between operand load and result commit, for the ALU critical path. Range 0-15; 0 skips the settle state.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ad  in  1  add request, level
- su  in  1  subtract request, level
- mu  in  1  multiply request, level
- v  in  1  ALU overflow flag, combinational from datapath
- ld_x  out  1  load x register
- ld_y  out  1  load y register, true form
- ld_y2c  out  1  load y register, two's-complement form
- alu_op  out  2  00 add, 01 sub, 10 mul-step, 11 unused
- mul_clr  out  1  clear multiply accumulator/counter in datapath
- mul_step  out  1  perform one shift-add step
- ld_res  out  1  commit ALU result to result register
- done  out  1  operation-complete pulse
- busy  out  1  high in every state except IDLE
- err  out  2  [0] overflow (sticky), [1] illegal request (sticky)

Behaviour:
- All outputs are registered (Moore, decoded from next state). Every output changes only on a rising clk edge, or asynchronously on reset.
- Reset (rst=0), asynchronous, at any time including mid-operation:
  - all outputs 0, alu_op=00, err=00, step counter 0;
  - state forced to HOLD, so a request held through reset never fires.
- States: IDLE, LOAD, SETTLE, MSTEP, COMMIT, DONE, HOLD.
- IDLE: requests are sampled only in this state.
  - Exactly one of {ad,su,mu} high: latch the op into alu_op, clear err to 00, go to LOAD.
  - Two or three high: set err[1]=1, go to HOLD, no datapath strobes.
  - None high: stay in IDLE.
- LOAD, 1 cycle:
  - ld_x=1 for all ops.
  - ld_y=1 for add and mul; ld_y2c=1 for sub. ld_y and ld_y2c are never high together.
  - mul only: mul_clr=1.
  - Next state: SETTLE if SETTLE>0; otherwise MSTEP (mul) or COMMIT (add/sub).
- SETTLE: exactly SETTLE cycles, all strobes 0, counter-based. Then MSTEP (mul) or COMMIT (add/sub).
- MSTEP (mul only):
  - exactly WIDTH cycles with mul_step=1 and alu_op=10;
  - counter runs 0..WIDTH-1, then goes to COMMIT;
  - v is sampled each MSTEP cycle and OR-accumulated into an internal overflow flag.
- COMMIT, 1 cycle:
  - Overflow is v sampled this cycle (add/sub) or the accumulated flag (mul).
  - No overflow: ld_res=1.
  - Overflow: ld_res stays 0, err[0] set to 1.
  - Next state: DONE.
- DONE, 1 cycle: done=1, also when overflow occurred. Next state: HOLD.
- HOLD: stay until ad=su=mu=0 is sampled, then go to IDLE. An op is never re-triggered by a held switch.
- alu_op holds the latched op from LOAD through DONE; returns to 00 in HOLD/IDLE.
- err holds its value until the next accepted op or reset.
- Latency: the acceptance edge E0 moves the state to LOAD.
  - add/sub: done high in the cycle after edge E(2+SETTLE).
  - mul: done high in the cycle after edge E(2+SETTLE+WIDTH).
- Request changes after acceptance are ignored until HOLD.
- Counter width is sized for max(WIDTH, SETTLE). No wrap-around beyond the terminal count.

Test Plan:
- Add, SETTLE=1: ad=1 for 1 cycle at IDLE -> ld_x=ld_y=1 one cycle, 1 idle cycle, ld_res=1 one cycle, done=1 on the next cycle (3rd cycle after LOAD); ld_y2c stays 0; err=00.
- Sub with v=1 in COMMIT: su held high throughout -> ld_x=ld_y2c=1, alu_op=01, ld_res stays 0, err=01, done=1; busy stays 1 and the state stays in HOLD until su drops, then busy=0 the cycle after the release is sampled.
- Mul, WIDTH=8, SETTLE=1: mu pulse -> mul_clr=1 with the load, exactly 8 consecutive mul_step=1 cycles, then ld_res=1, then done=1 exactly 11 cycles after LOAD begins; v=1 on step 3 only -> ld_res=0, err=01.
- Illegal request: ad=su=1 together at IDLE -> no ld_x/ld_y/ld_y2c/ld_res/done; err=10 sticky; a subsequent single legal ad after release clears err to 00 and runs normally.
- Reset mid-mul: rst=0 during step 4 with mu still high -> all outputs 0 immediately; after rst=1, no operation starts until mu is released and re-asserted.
- SETTLE=0 build: ad pulse -> ld_res=1 in the cycle directly after LOAD, done=1 the cycle after that.
